tank_sprite_renderer: RTL and testbench
=======================================

# tank_sprite_renderer

- Downstream of the tank position stage; upstream of the VGA adapter pixel-write port.
- Watches the 8-bit tank x position and, on each change, repaints the tank sprite in the 160x120 frame buffer:
  - first it erases the old rectangle with the background colour;
  - then it draws the new rectangle in the tank colour.
- It writes one pixel per clock and replaces the single-pixel direct drive of the adapter.

## Interface
- TANK_W, 8: sprite width in pixels (1..16).
- TANK_H, 4: sprite height in pixels (1..8).
- TANK_Y, 110: top row of sprite; TANK_Y+TANK_H must be <= 120.
- SCREEN_W, 160: visible columns; pixels at x >= SCREEN_W are suppressed.
- FG_COLOUR, 3'b010: tank colour.
- BG_COLOUR, 3'b000: erase colour.
- clk  in  1  system clock (50 MHz).
- resetn  in  1  asynchronous, active-low reset.
- xpos  in  8  requested tank left-edge column, from the position stage.
- vga_x  out  8  pixel column to adapter.
- vga_y  out  7  pixel row to adapter.
- vga_colour  out  3  pixel colour to adapter.
- vga_plot  out  1  write strobe to adapter; one pixel written per high cycle.
- busy  out  1  high while in ERASE or DRAW.
- done  out  1  one-cycle pulse on the last DRAW pixel cycle.

## Operation
- Registers:
  - state: LOAD, ERASE, DRAW, IDLE;
  - drawn_x[7:0]: position currently on screen;
  - target_x[7:0];
  - col counter, 0..TANK_W-1;
  - row counter, 0..TANK_H-1;
  - first flag.
- Reset (async, resetn=0):
  - state=LOAD, drawn_x=0, target_x=0, counters=0, first=1;
  - all outputs 0.
- LOAD:
  - latch target_x<=xpos;
  - go to DRAW if first=1 (nothing to erase), else to ERASE;
  - clear counters.
- ERASE: sweeps base drawn_x with BG_COLOUR. On the last pixel: go to DRAW, clear counters.
- DRAW:
  - sweeps base target_x with FG_COLOUR;
  - on the last pixel: drawn_x<=target_x, first<=0, done=1, go to IDLE.
- IDLE:
  - if xpos != drawn_x go to LOAD, otherwise stay;
  - plot=0, busy=0.
- Sweep order is row-major: col increments every cycle, and on col=TANK_W-1 it wraps to 0 and row increments. The last pixel is col=TANK_W-1, row=TANK_H-1.
- Pixel address:
  - vga_x = base + col, computed 9 bits wide, output low 8 bits;
  - vga_y = TANK_Y + row.
- Clipping: vga_plot=0 for any pixel whose 9-bit column sum >= SCREEN_W. The cycle is still consumed, so the sweep length is constant.
- vga_colour: BG_COLOUR in ERASE, FG_COLOUR in DRAW, 0 otherwise.
- xpos changes while busy are ignored. Only the value present in IDLE/LOAD is used, so intermediate positions are dropped.
- If xpos equals drawn_x in IDLE, no traffic is generated.

## Timing
- All outputs are decoded from registered state and counters; there is no combinational path from xpos to any output.
- A full repaint takes 1 (LOAD) + TANK_W*TANK_H (ERASE) + TANK_W*TANK_H (DRAW) cycles, giving 65 cycles at default parameters.
- First repaint after reset has no ERASE: 1 + TANK_W*TANK_H cycles.
- xpos change sampled in IDLE at edge N:
  - LOAD occupies cycle N+1;
  - the first ERASE plot is visible in cycle N+2.
- done coincides with the final DRAW plot cycle. busy drops in the following cycle.
- After done, the first IDLE cycle can detect a new mismatch, so the minimum gap between repaints is 1 IDLE cycle.
- An async reset during ERASE or DRAW aborts immediately:
  - outputs go 0 in the same cycle;
  - the partial sprite is left in the frame buffer (not cleaned);
  - after release, the first repaint draws at the current xpos without erase.

## Test plan
- Reset release with xpos=0: 32 consecutive plot cycles with FG_COLOUR covering x 0..7, y 110..113 in row-major order, done on the 32nd, then IDLE with plot=0.
- After settling at 0, step xpos to 20:
  - LOAD cycle;
  - 32 BG plots at x 0..7;
  - 32 FG plots at x 20..27;
  - done, drawn_x=20.
- xpos=156 from drawn_x=150: in DRAW, columns 156..159 are plotted and 160..163 have plot=0; sweep length is still 32 cycles.
- Toggle xpos 20->21->22 during ERASE: exactly one repaint (erase 20, draw 22, or the value held at LOAD), then a repaint for any later mismatch only.
- Assert resetn low mid-DRAW (pixel 10): plot, busy and done go 0 immediately. After release, draw-only repaint at the current xpos with no ERASE plots.
- Hold xpos constant for 1000 cycles after done: zero plot pulses, busy=0 throughout.

Source files
------------

// File: rtl/tank_sprite_renderer_if.sv
// Pixel-write bus between the tank sprite renderer and the VGA adapter.
// The renderer also takes the requested position and reports its progress here.
interface tank_sprite_renderer_if;
    logic [7:0] xpos;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    modport master (
        input  xpos,
        output vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        output xpos,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, done
    );
endinterface

// File: rtl/tank_sprite_renderer.sv
// Repaints the tank sprite whenever xpos moves: erases the old rectangle, then draws
// the new one, one pixel per clock. Columns at or beyond SCREEN_W are not plotted.
module tank_sprite_renderer #(
    parameter int unsigned TANK_W    = 8,
    parameter int unsigned TANK_H    = 4,
    parameter int unsigned TANK_Y    = 110,
    parameter int unsigned SCREEN_W  = 160,
    parameter logic [2:0]  FG_COLOUR = 3'b010,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic                          clk,
    input  logic                          resetn,
    tank_sprite_renderer_if.master        bus
);

    localparam logic [3:0] LastCol = 4'(TANK_W - 1);
    localparam logic [2:0] LastRow = 3'(TANK_H - 1);

    typedef enum logic [1:0] {StLoad, StErase, StDraw, StIdle} state_e;

    state_e     state_q, state_d;
    logic [7:0] drawn_x_q, drawn_x_d;
    logic [7:0] target_x_q, target_x_d;
    logic [3:0] col_q, col_d;
    logic [2:0] row_q, row_d;
    logic       first_q, first_d;

    logic       last_pix;
    logic       sweeping;
    logic [7:0] base;
    logic [8:0] col_sum;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StLoad;
            drawn_x_q  <= 8'd0;
            target_x_q <= 8'd0;
            col_q      <= 4'd0;
            row_q      <= 3'd0;
            first_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            drawn_x_q  <= drawn_x_d;
            target_x_q <= target_x_d;
            col_q      <= col_d;
            row_q      <= row_d;
            first_q    <= first_d;
        end
    end

    assign last_pix = (col_q == LastCol) && (row_q == LastRow);

    always_comb begin
        state_d    = state_q;
        drawn_x_d  = drawn_x_q;
        target_x_d = target_x_q;
        col_d      = col_q;
        row_d      = row_q;
        first_d    = first_q;
        unique case (state_q)
            StLoad: begin
                // Only the position seen here is used; later moves wait for IDLE.
                target_x_d = bus.xpos;
                col_d      = 4'd0;
                row_d      = 3'd0;
                state_d    = first_q ? StDraw : StErase;
            end
            StErase, StDraw: begin
                if (last_pix) begin
                    col_d = 4'd0;
                    row_d = 3'd0;
                    if (state_q == StErase) begin
                        state_d = StDraw;
                    end else begin
                        drawn_x_d = target_x_q;
                        first_d   = 1'b0;
                        state_d   = StIdle;
                    end
                end else if (col_q == LastCol) begin
                    col_d = 4'd0;
                    row_d = row_q + 3'd1;
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
            StIdle: begin
                if (bus.xpos != drawn_x_q) begin
                    state_d = StLoad;
                end
            end
        endcase
    end

    // Outputs decode registered state only, so xpos never reaches them combinationally.
    assign sweeping = (state_q == StErase) || (state_q == StDraw);
    assign base     = (state_q == StErase) ? drawn_x_q : target_x_q;
    assign col_sum  = {1'b0, base} + {5'd0, col_q};

    always_comb begin
        bus.vga_x      = 8'd0;
        bus.vga_y      = 7'd0;
        bus.vga_colour = 3'd0;
        bus.vga_plot   = 1'b0;
        bus.busy       = sweeping;
        bus.done       = (state_q == StDraw) && last_pix;
        if (sweeping) begin
            bus.vga_x      = col_sum[7:0];
            bus.vga_y      = 7'(TANK_Y) + {4'd0, row_q};
            bus.vga_colour = (state_q == StErase) ? BG_COLOUR : FG_COLOUR;
            bus.vga_plot   = col_sum < 9'(SCREEN_W);
        end
    end

endmodule

// File: tb/tb_tank_sprite_renderer.sv
// Bench for tank_sprite_renderer: a queue of expected per-cycle outputs built from the
// repaint rules is compared every cycle, plus directed scenarios with literal expectations.
module tb_tank_sprite_renderer;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int TY   = 110;
    localparam int SW   = 160;
    localparam int FG   = 2;
    localparam int BG   = 0;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    tank_sprite_renderer_if bus ();

    tank_sprite_renderer dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Expected output of one cycle; is_load / is_last mark the repaint milestones.
    typedef struct packed {
        logic       plot;
        logic       busy;
        logic       done;
        logic [2:0] colour;
        logic [7:0] x;
        logic [6:0] y;
        logic       is_load;
        logic       is_last;
    } ent_t;

    ent_t q[$];
    int   m_drawn  = 0;
    int   m_target = 0;
    bit   m_first  = 1'b1;

    function automatic ent_t load_ent();
        ent_t e;
        e = '0;
        e.is_load = 1'b1;
        return e;
    endfunction

    function automatic void push_sweep(input int base, input bit is_draw);
        ent_t e;
        for (int k = 0; k < W * H; k++) begin
            int x9;
            x9 = base + (k % W);
            e = '0;
            e.plot    = (x9 < SW);
            e.busy    = 1'b1;
            e.done    = is_draw && (k == W * H - 1);
            e.colour  = is_draw ? 3'(FG) : 3'(BG);
            e.x       = x9[7:0];
            e.y       = 7'(TY + k / W);
            e.is_last = e.done;
            q.push_back(e);
        end
    endfunction

    always @(posedge clk or negedge resetn) begin
        ent_t e;
        if (!resetn) begin
            q.delete();
            q.push_back(load_ent());
            m_first = 1'b1;
            m_drawn = 0;
        end else if (q.size() == 0) begin
            if (int'(bus.xpos) != m_drawn) q.push_back(load_ent());
        end else begin
            e = q.pop_front();
            if (e.is_load) begin
                m_target = int'(bus.xpos);
                if (!m_first) push_sweep(m_drawn, 1'b0);
                push_sweep(m_target, 1'b1);
            end else if (e.is_last) begin
                m_drawn = m_target;
                m_first = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [20:0] expv;
        logic [20:0] actv;
        if (chk_en) begin
            expv = '0;
            if (q.size() != 0)
                expv = {q[0].plot, q[0].busy, q[0].done, q[0].colour, q[0].x, q[0].y};
            actv = {bus.vga_plot, bus.busy, bus.done, bus.vga_colour, bus.vga_x, bus.vga_y};
            checks++;
            if (actv !== expv) begin
                errors++;
                $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, actv, expv);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    int n_cyc, plot_cnt, fg_cnt, bg_cnt, busy_cnt, first_n, first_x, last_x, last_y;

    task automatic clear_counts();
        n_cyc = 0; plot_cnt = 0; fg_cnt = 0; bg_cnt = 0; busy_cnt = 0;
        first_n = -1; first_x = -1; last_x = -1; last_y = -1;
    endtask

    task automatic sample();
        n_cyc++;
        if (bus.busy) busy_cnt++;
        if (bus.vga_plot) begin
            plot_cnt++;
            if (int'(bus.vga_colour) == FG) fg_cnt++;
            else if (int'(bus.vga_colour) == BG) bg_cnt++;
            if (first_n < 0) begin
                first_n = n_cyc;
                first_x = int'(bus.vga_x);
            end
            last_x = int'(bus.vga_x);
            last_y = int'(bus.vga_y);
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        clear_counts();
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            sample();
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", int'(seen), 1);
    endtask

    task automatic run_idle(input int n);
        clear_counts();
        repeat (n) begin
            @(negedge clk);
            sample();
        end
    endtask

    task automatic set_x(input int v);
        @(negedge clk);
        #1 bus.xpos = 8'(v);
    endtask

    initial begin
        bus.xpos = 8'd0;
        @(posedge clk);
        chk_en = 1'b1;
        #1;
        check("reset_plot", int'(bus.vga_plot), 0);
        check("reset_busy", int'(bus.busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 resetn = 1'b1;

        // First repaint after reset: draw only.
        wait_done();
        check("first_len", n_cyc, 32);
        check("first_fg", fg_cnt, 32);
        check("first_bg", bg_cnt, 0);
        check("first_x0", first_x, 0);
        check("first_lastx", last_x, 7);
        check("first_lasty", last_y, 113);
        run_idle(5);
        check("settle_plots", plot_cnt, 0);

        // Step to 20: LOAD, erase at 0, draw at 20.
        set_x(20);
        wait_done();
        check("step_len", n_cyc, 65);
        check("step_bg", bg_cnt, 32);
        check("step_fg", fg_cnt, 32);
        check("step_first_n", first_n, 2);
        check("step_first_x", first_x, 0);
        check("step_lastx", last_x, 27);

        // Clipping at the right edge.
        set_x(150);
        wait_done();
        set_x(156);
        wait_done();
        check("clip_len", n_cyc, 65);
        check("clip_fg", fg_cnt, 16);
        check("clip_bg", bg_cnt, 32);
        check("clip_busy", busy_cnt, 64);
        check("clip_lastx", last_x, 159);
        check("clip_lasty", last_y, 113);

        // Move during LOAD: only the value present at the end of LOAD is drawn.
        set_x(20);
        wait_done();
        set_x(21);
        set_x(22);
        wait_done();
        check("toggle_len", n_cyc, 64);
        check("toggle_first_x", first_x, 20);
        check("toggle_lastx", last_x, 29);
        check("toggle_fg", fg_cnt, 32);
        run_idle(50);
        check("toggle_after_plots", plot_cnt, 0);

        // Reset mid-DRAW at pixel 10.
        set_x(40);
        repeat (44) @(negedge clk);
        check("mid_x", int'(bus.vga_x), 42);
        check("mid_y", int'(bus.vga_y), 111);
        check("mid_plot", int'(bus.vga_plot), 1);
        #1 resetn = 1'b0;
        #1;
        check("abort_plot", int'(bus.vga_plot), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;
        wait_done();
        check("redraw_len", n_cyc, 32);
        check("redraw_bg", bg_cnt, 0);
        check("redraw_first_x", first_x, 40);
        check("redraw_lastx", last_x, 47);

        // Steady position: no traffic.
        run_idle(1000);
        check("hold_plots", plot_cnt, 0);
        check("hold_busy", busy_cnt, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
